// File: rtl/mxv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mxv_sequencer
// Description : Row/column sequencer for a DIM x DIM matrix-vector multiply:
//               MAC clear/accumulate strobes, settle wait, req/ack hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module mxv_sequencer #(
    parameter int DIM             = 3,
    parameter int NBITS_FOR_INDEX = 2,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       send_ack,
    output logic                       busy,
    output logic [NBITS_FOR_INDEX-1:0] row_idx,
    output logic [NBITS_FOR_INDEX-1:0] col_idx,
    output logic                       mac_clear,
    output logic                       mac_en,
    output logic                       send_req,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_MAC    = 3'd2,
        S_SETTLE = 3'd3,
        S_SEND   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [NBITS_FOR_INDEX-1:0] c_last_idx    = NBITS_FOR_INDEX'(DIM - 1);
    localparam logic [3:0]                 c_settle_last = 4'(SETTLE_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [NBITS_FOR_INDEX-1:0] row_q, row_d;
    logic [NBITS_FOR_INDEX-1:0] col_q, col_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic                       clr_q, clr_d;
    logic                       en_q, en_d;
    logic                       req_q, req_d;
    logic                       done_q, done_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_CLEAR: begin
                col_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (col_q == c_last_idx) begin
                    col_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == c_settle_last) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (send_ack) begin
                    if (row_q == c_last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                row_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        clr_d  = (state_d == S_CLEAR);
        en_d   = (state_d == S_MAC);
        req_d  = (state_d == S_SEND);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign mac_clear = clr_q;
    assign mac_en    = en_q;
    assign send_req  = req_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mxv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mxv_sequencer
// Description : Directed + randomized bench; expected per-cycle output trace
//               is built from the row/column schedule with plain loops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mxv_sequencer;

    // {busy, row[1:0], col[1:0], mac_clear, mac_en, send_req, done}
    typedef logic [8:0] vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, ack0, start1, ack1;
    logic       busy0, clr0, en0, req0, done0;
    logic       busy1, clr1, en1, req1, done1;
    logic [1:0] row0, col0, row1, col1;

    int   errors = 0;
    int   checks = 0;
    int   waits[4];
    vec_t exp_q[$];
    bit   ack_q[$];

    always #5 clk = ~clk;

    mxv_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start0), .send_ack(ack0),
        .busy(busy0), .row_idx(row0), .col_idx(col0), .mac_clear(clr0),
        .mac_en(en0), .send_req(req0), .done(done0)
    );

    mxv_sequencer #(.DIM(4), .NBITS_FOR_INDEX(2), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .send_ack(ack1),
        .busy(busy1), .row_idx(row1), .col_idx(col1), .mac_clear(clr1),
        .mac_en(en1), .send_req(req1), .done(done1)
    );

    function automatic vec_t mk(int b, int r, int c, int cl, int en, int rq, int dn);
        return {1'(b), 2'(r), 2'(c), 1'(cl), 1'(en), 1'(rq), 1'(dn)};
    endfunction

    function automatic vec_t sample(int sel);
        if (sel == 0) return {busy0, row0, col0, clr0, en0, req0, done0};
        return {busy1, row1, col1, clr1, en1, req1, done1};
    endfunction

    task automatic drive(int sel, logic s, logic a);
        if (sel == 0) begin start0 = s; ack0 = a; end
        else          begin start1 = s; ack1 = a; end
    endtask

    task automatic check(string tag, vec_t got, vec_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected trace: per row one clear, DIM accumulates, SETTLE quiet cycles,
    // then send_req until the ack; a single done cycle closes the run.
    // ack_q[i] is the send_ack value presented while exp_q[i] is visible.
    task automatic build(int dim, int settle);
        exp_q.delete();
        ack_q.delete();
        for (int r = 0; r < dim; r++) begin
            exp_q.push_back(mk(1, r, 0, 1, 0, 0, 0)); ack_q.push_back(1'($urandom % 2));
            for (int c = 0; c < dim; c++) begin
                exp_q.push_back(mk(1, r, c, 0, 1, 0, 0)); ack_q.push_back(1'($urandom % 2));
            end
            for (int s = 0; s < settle; s++) begin
                exp_q.push_back(mk(1, r, 0, 0, 0, 0, 0)); ack_q.push_back(1'($urandom % 2));
            end
            for (int w = 0; w <= waits[r]; w++) begin
                exp_q.push_back(mk(1, r, 0, 0, 0, 1, 0)); ack_q.push_back(w == waits[r]);
            end
        end
        exp_q.push_back(mk(1, dim - 1, 0, 0, 0, 0, 1)); ack_q.push_back(1'($urandom % 2));
    endtask

    task automatic run(int sel, int dim, int settle, bit noisy, int abort_idx,
                       int exp_len, string tag);
        vec_t got;
        int   busy_cnt = 0;
        int   en_cnt   = 0;
        build(dim, settle);
        drive(sel, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = sample(sel);
            busy_cnt += int'(got[8]);
            en_cnt   += int'(got[2]);
            check($sformatf("%s.cyc%0d", tag, i), got, exp_q[i]);
            if (i == abort_idx) begin
                reset = 1'b1;
                drive(sel, 1'b0, 1'b0);
                @(posedge clk); @(negedge clk);
                check({tag, ".after_reset"}, sample(sel), '0);
                reset = 1'b0;
                return;
            end
            drive(sel, noisy ? 1'($urandom % 2) : 1'b0, ack_q[i]);
            @(posedge clk); @(negedge clk);
        end
        drive(sel, 1'b0, 1'b0);
        check({tag, ".idle_after"}, sample(sel), '0);
        check_int({tag, ".busy_cycles"}, busy_cnt, exp_len);
        check_int({tag, ".mac_en_cycles"}, en_cnt, dim * dim);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset0", sample(0), '0);
        check("reset1", sample(1), '0);
        reset = 1'b0;

        // Idle with start low stays put, ack in IDLE ignored.
        drive(0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_hold", sample(0), '0);
        drive(0, 1'b0, 1'b0);

        waits = '{0, 0, 0, 0};
        run(0, 3, 2, 1'b0, -1, 22, "basic");

        waits = '{0, 5, 0, 0};
        run(0, 3, 2, 1'b0, -1, 27, "ack_wait");

        waits = '{0, 0, 0, 0};
        run(0, 3, 2, 1'b1, -1, 22, "start_noise");

        // Abort during row 1 accumulate at col_idx=1 (trace index 9).
        run(0, 3, 2, 1'b0, 9, 22, "abort");
        run(0, 3, 2, 1'b0, -1, 22, "after_abort");

        // Reset wins over start in the same cycle.
        reset = 1'b1;
        drive(0, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0);
        check("reset_vs_start", sample(0), '0);
        @(posedge clk); @(negedge clk);
        check("reset_vs_start_idle", sample(0), '0);

        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 4; r++) waits[r] = int'($urandom_range(0, 3));
            run(0, 3, 2, 1'b1, -1, 22 + waits[0] + waits[1] + waits[2],
                $sformatf("rand%0d", k));
        end

        waits = '{0, 0, 0, 0};
        run(1, 4, 1, 1'b0, -1, 29, "dim4");
        for (int r = 0; r < 4; r++) waits[r] = int'($urandom_range(0, 4));
        run(1, 4, 1, 1'b1, -1, 29 + waits[0] + waits[1] + waits[2] + waits[3], "dim4_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mxv_sequencer.md
Name: mxv_sequencer

Overview:
Top-level controller for the matrix-vector multiply datapath. It sequences row/column addressing of a DIM x DIM matrix against a DIM-element vector and drives the MAC clear and accumulate strobes. After each row it waits a fixed settle time for the MAC pipeline, then hands each row result to the transmit path through a req/ack handshake. It sits between the start command and the MAC unit / send path; one run produces DIM results.

Parameters:
DIM, 3, matrix dimension (rows = columns = vector length); legal range 2..2**NBITS_FOR_INDEX.
NBITS_FOR_INDEX, 2, width of row/column index outputs.
SETTLE_CYCLES, 2, MAC pipeline latency in cycles between the last accumulate and a valid result; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high; sampled on rising clk.
start  input  1  begin a run; sampled only in IDLE.
send_ack  input  1  transmit path has accepted the current result; sampled only in SEND.
busy  output  1  high in every state except IDLE.
row_idx  output  NBITS_FOR_INDEX  current matrix row / result index.
col_idx  output  NBITS_FOR_INDEX  current matrix column / vector element index.
mac_clear  output  1  one-cycle accumulator clear.
mac_en  output  1  accumulate strobe; one product per cycle.
send_req  output  1  current row result is valid; held until ack.
done  output  1  one-cycle pulse when the final result is accepted.

Behaviour:
- All outputs registered. Reset (synchronous, high): state=IDLE, row_idx=0, col_idx=0, settle counter=0, every output 0. Reset takes precedence over every other input, including mid-run and in the same cycle as start.
- States: IDLE, CLEAR, MAC, SETTLE, SEND, DONE.
- IDLE: busy=0. start=1 -> CLEAR with row_idx=0, col_idx=0. start=0 -> stay.
- CLEAR: mac_clear=1 for exactly 1 cycle; col_idx=0 -> MAC.
- MAC: mac_en=1 for exactly DIM consecutive cycles, col_idx=0,1,..,DIM-1 (one per cycle). When col_idx=DIM-1: -> SETTLE, col_idx returns to 0.
- SETTLE: all strobes low; counter runs SETTLE_CYCLES cycles, then -> SEND.
- SEND: send_req=1, row_idx stable. send_ack=1 -> if row_idx=DIM-1 -> DONE, else row_idx+1 and -> CLEAR. send_ack=0 -> hold indefinitely; no timeout.
- DONE: done=1 for 1 cycle, busy=1 -> IDLE; row_idx returns to 0.
- start outside IDLE is ignored (no queuing, no restart). send_ack outside SEND is ignored.
- Index counters never exceed DIM-1; no modulo wrap beyond DIM.
- Row time with immediate ack = 1 + DIM + SETTLE_CYCLES + 1 cycles. Run time = DIM x row time + 1 (DONE).
- Defaults (DIM=3, SETTLE_CYCLES=2): row time 7 cycles; run time 22 cycles from the first busy cycle to the DONE cycle, inclusive.
- mac_clear, mac_en, send_req and done are mutually exclusive in every cycle.

Test Plan:
- Reset, then a 1-cycle start pulse, send_ack tied high -> busy for exactly 22 cycles; mac_clear pulses 3 times; 9 mac_en cycles with col_idx 0,1,2 per row; send_req at row_idx 0,1,2; a single done pulse; back in IDLE.
- Defaults, send_ack held low 5 cycles in row 1 -> send_req stays high with row_idx=1 for 6 cycles; run time 27 cycles; no extra mac_en.
- start re-pulsed during MAC and SEND -> no effect; sequence and cycle counts identical to the first scenario.
- reset asserted during row 1 MAC (col_idx=1) -> next cycle state IDLE, all outputs 0, indices 0; a later start runs a full clean 22-cycle sequence.
- send_ack pulsed in IDLE, CLEAR and SETTLE -> ignored; row_idx advances only on an ack in SEND.
- DIM=4, SETTLE_CYCLES=1, immediate ack -> row time 7; run time 29 cycles; col_idx reaches 3; 16 mac_en cycles total.
